ceespu_forward_unit: RTL

CEESPU_FORWARD_UNIT -- requirements
Module: ceespu_forward_unit

---
 rtl/ceespu_pkg.sv | 34 +++
 rtl/ceespu_forward_unit_if.sv | 31 +++
 rtl/ceespu_forward_unit_fwd_mux.sv | 39 +++
 rtl/ceespu_forward_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/ceespu_pkg.sv
// Shared widths, pipeline-entry type and tag-compare helper for the
// ceespu operand-forwarding logic.
package ceespu_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int REGW = $clog2(NREG);
    localparam int NSRC = 3;

    // One tracked pipeline slot; the E slot leaves data at zero.
    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic                   is_load;
        logic [REGW-1:0]        reg_d;
        logic [NSRC*REGW-1:0]   srcs;
        logic [NSRC-1:0]        use_s;
        logic [XLEN-1:0]        data;
    } stage_t;

    function automatic logic tag_match(
        input logic            en,
        input logic [REGW-1:0] src_tag,
        input logic [REGW-1:0] dst_tag,
        input bit              zero_reg
    );
        if (zero_reg && (src_tag == {REGW{1'b0}})) begin
            return 1'b0;
        end else begin
            return en && (src_tag == dst_tag);
        end
    endfunction

endpackage

// File: rtl/ceespu_forward_unit_if.sv
// Decode/E-stage bus between the ceespu pipeline and its forwarding unit.
interface ceespu_forward_unit_if;

    logic                                                 I_stall;
    logic                                                 I_flush;
    logic                                                 I_dec_we;
    logic                                                 I_dec_isLoad;
    logic [ceespu_pkg::REGW-1:0]                          I_dec_regD;
    logic [ceespu_pkg::NSRC*ceespu_pkg::REGW-1:0]         I_dec_regS;
    logic [ceespu_pkg::NSRC-1:0]                          I_dec_useS;
    logic [ceespu_pkg::NSRC*ceespu_pkg::XLEN-1:0]         I_reg_data;
    logic [ceespu_pkg::XLEN-1:0]                          I_ex_result;
    logic [ceespu_pkg::XLEN-1:0]                          I_wb_result;
    logic [ceespu_pkg::NSRC*ceespu_pkg::XLEN-1:0]         O_operand;
    logic                                                 O_stall;
    logic                                                 O_ex_valid;
    logic [15:0]                                          O_hazard_cnt;

    modport master (
        output I_stall, I_flush, I_dec_we, I_dec_isLoad, I_dec_regD,
               I_dec_regS, I_dec_useS, I_reg_data, I_ex_result, I_wb_result,
        input  O_operand, O_stall, O_ex_valid, O_hazard_cnt
    );

    modport slave (
        input  I_stall, I_flush, I_dec_we, I_dec_isLoad, I_dec_regD,
               I_dec_regS, I_dec_useS, I_reg_data, I_ex_result, I_wb_result,
        output O_operand, O_stall, O_ex_valid, O_hazard_cnt
    );

endinterface

// File: rtl/ceespu_forward_unit_fwd_mux.sv
// Per-source operand select: W result first, then the youngest matching
// older writer, else the register-file value.
module ceespu_fwd_mux
    import ceespu_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [REGW-1:0]             i_tag,
    input  logic                        i_use,
    input  logic [XLEN-1:0]             i_reg_data,
    input  logic [XLEN-1:0]             i_wb_result,
    input  logic [DEPTH-1:0]            i_wr_en,
    input  logic [DEPTH*REGW-1:0]       i_wr_tag,
    input  logic [(DEPTH-1)*XLEN-1:0]   i_h_data,
    output logic [XLEN-1:0]             o_operand
);

    logic [XLEN-1:0] w_sel;

    // Oldest writer is applied first so younger hits overwrite it.
    always_comb begin
        w_sel = i_reg_data;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            if (tag_match(i_wr_en[k], i_tag, i_wr_tag[k*REGW +: REGW], ZERO_REG)) begin
                w_sel = i_h_data[(k-1)*XLEN +: XLEN];
            end else begin
                w_sel = w_sel;
            end
        end
        if (tag_match(i_wr_en[0], i_tag, i_wr_tag[0 +: REGW], ZERO_REG)) begin
            w_sel = i_wb_result;
        end else begin
            w_sel = w_sel;
        end
        o_operand = i_use ? w_sel : i_reg_data;
    end

endmodule

// File: rtl/ceespu_forward_unit.sv
// Operand forwarding and load-use hazard detection for the ceespu pipeline.
// Slot 0 of the tag pipeline is E, slot 1 is W, slots 2..DEPTH are H1..H(DEPTH-1).
module ceespu_forward_unit
    import ceespu_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    ceespu_forward_unit_if.slave  bus
);

    localparam int NST = DEPTH + 1;

    stage_t                     r_pipe [NST];
    logic [15:0]                r_hazard_cnt;

    stage_t                     w_dec_entry;
    stage_t                     w_e_next;
    stage_t                     w_w_next;
    stage_t                     w_h1_next;
    logic                       w_load_use;
    logic                       w_stall;
    logic [DEPTH-1:0]           w_wr_en;
    logic [DEPTH*REGW-1:0]      w_wr_tag;
    logic [(DEPTH-1)*XLEN-1:0]  w_h_data;
    logic [NSRC*XLEN-1:0]       w_operand;

    // Decode entry, load-use detection and next-slot contents.
    always_comb begin
        w_dec_entry         = '0;
        w_dec_entry.valid   = 1'b1;
        w_dec_entry.we      = bus.I_dec_we;
        w_dec_entry.is_load = bus.I_dec_isLoad;
        w_dec_entry.reg_d   = bus.I_dec_regD;
        w_dec_entry.srcs    = bus.I_dec_regS;
        w_dec_entry.use_s   = bus.I_dec_useS;

        w_load_use = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            w_load_use = w_load_use | (bus.I_dec_useS[s] &
                tag_match(1'b1, bus.I_dec_regS[s*REGW +: REGW], r_pipe[0].reg_d, ZERO_REG));
        end
        w_stall = r_pipe[0].valid & r_pipe[0].we & r_pipe[0].is_load & w_load_use & ~bus.I_flush;

        w_e_next       = (bus.I_flush || w_stall) ? stage_t'('0) : w_dec_entry;
        w_w_next       = r_pipe[0];
        w_w_next.data  = bus.I_ex_result;
        w_h1_next      = r_pipe[1];
        w_h1_next.data = bus.I_wb_result;
    end

    // Flatten the writer slots (W, H1..) into the mux-facing vectors.
    always_comb begin
        w_wr_en  = '0;
        w_wr_tag = '0;
        w_h_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_wr_en[k]                 = r_pipe[k+1].valid & r_pipe[k+1].we;
            w_wr_tag[k*REGW +: REGW]   = r_pipe[k+1].reg_d;
        end
        for (int k = 1; k < DEPTH; k++) begin
            w_h_data[(k-1)*XLEN +: XLEN] = r_pipe[k+1].data;
        end
    end

    // Tag pipeline advance and load-use counter; everything holds on I_stall.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            for (int i = 0; i < NST; i++) begin
                r_pipe[i] <= '0;
            end
            r_hazard_cnt <= 16'h0000;
        end else if (!bus.I_stall) begin
            r_pipe[0] <= w_e_next;
            r_pipe[1] <= w_w_next;
            r_pipe[2] <= w_h1_next;
            for (int k = 3; k < NST; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            if (w_stall && (r_hazard_cnt != 16'hFFFF)) begin
                r_hazard_cnt <= r_hazard_cnt + 16'd1;
            end else begin
                r_hazard_cnt <= r_hazard_cnt;
            end
        end else begin
            r_hazard_cnt <= r_hazard_cnt;
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        ceespu_fwd_mux #(
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_mux (
            .i_tag       (r_pipe[0].srcs[s*REGW +: REGW]),
            .i_use       (r_pipe[0].use_s[s]),
            .i_reg_data  (bus.I_reg_data[s*XLEN +: XLEN]),
            .i_wb_result (bus.I_wb_result),
            .i_wr_en     (w_wr_en),
            .i_wr_tag    (w_wr_tag),
            .i_h_data    (w_h_data),
            .o_operand   (w_operand[s*XLEN +: XLEN])
        );
    end

    assign bus.O_operand    = w_operand;
    assign bus.O_stall      = w_stall;
    assign bus.O_ex_valid   = r_pipe[0].valid;
    assign bus.O_hazard_cnt = r_hazard_cnt;

endmodule
